// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-controller types, defaults and NOP encoding
package pipe_pkg;
    localparam int REG_W_DEF = 5;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_lu_detect.sv
// pipe_lu_detect: combinational load-use hazard compare, $0 never hazards
module pipe_lu_detect #(
    parameter int REG_W = pipe_pkg::REG_W_DEF
) (
    input  logic             memread_ex_i,
    input  logic [REG_W-1:0] writereg_ex_i,
    input  logic [REG_W-1:0] ins_rs_i,
    input  logic [REG_W-1:0] ins_rt_i,
    input  logic             uses_rt_id_i,
    output logic             lu_hazard_o
);
    assign lu_hazard_o = memread_ex_i & (writereg_ex_i != '0) &
                         ((writereg_ex_i == ins_rs_i) | (uses_rt_id_i & (writereg_ex_i == ins_rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush sequencer with memory-wait timeout and stall counter
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int DMEM_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] writereg_ex,
    input  logic [REG_W-1:0] ins_rs,
    input  logic [REG_W-1:0] ins_rt,
    input  logic             uses_rt_id,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [7:0] TIMEOUT = 8'(DMEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q;
    logic             lu_hazard, mem_stall, hold, flush, lu_stall;

    pipe_lu_detect #(.REG_W(REG_W)) u_lu (
        .memread_ex_i (memread_ex),
        .writereg_ex_i(writereg_ex),
        .ins_rs_i     (ins_rs),
        .ins_rt_i     (ins_rt),
        .uses_rt_id_i (uses_rt_id),
        .lu_hazard_o  (lu_hazard)
    );

    assign mem_stall = dmem_req & ~dmem_ready;

    // RUN and a released MEMWAIT share one priority chain; ERR freezes everything
    always_comb begin
        hold     = (state_q == ST_ERR) | mem_stall;
        flush    = ~hold & branch_taken_ex;
        lu_stall = ~hold & ~branch_taken_ex & lu_hazard;
    end

    assign pc_hold      = rst_n & (hold | lu_stall);
    assign ifid_hold    = rst_n & (hold | lu_stall);
    assign idex_hold    = rst_n & hold;
    assign exmem_hold   = rst_n & hold;
    assign ifid_flush   = rst_n & flush;
    assign idex_flush   = rst_n & (flush | lu_stall);
    assign memwb_bubble = rst_n & hold;
    assign dmem_err     = err_q;
    assign stall_cnt    = stall_q;

    // next state: count wait cycles, escalate to ERR when the budget is used up
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEMWAIT;
                    wcnt_d  = 8'd1;
                end
            end
            ST_MEMWAIT: begin
                if (mem_stall) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_d == TIMEOUT) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                    wcnt_d  = 8'd0;
                end
            end
            default: state_d = ST_ERR;
        endcase
    end

    // state, wait counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wcnt_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // saturating count of cycles the PC is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else if (pc_hold && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven combinational checks plus multi-cycle hazard sequences
module tb_pipe_hazard_ctrl;
    localparam int CW = 4;
    localparam logic [6:0] Z     = 7'b0000000;
    localparam logic [6:0] HOLD  = 7'b1111001;
    localparam logic [6:0] FLUSH = 7'b0000110;
    localparam logic [6:0] LU    = 7'b1100010;

    typedef struct {
        logic       mr;
        logic [4:0] wr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    logic clk = 0, rst_n = 0;
    logic memread_ex = 0, uses_rt_id = 0, branch_taken_ex = 0, dmem_req = 0, dmem_ready = 0;
    logic [4:0] writereg_ex = 0, ins_rs = 0, ins_rt = 0;
    logic pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_bubble, dmem_err;
    logic [CW-1:0] stall_cnt;
    logic [6:0] ctrl;
    int total = 0, bad = 0;
    vec_t tbl[12];

    assign ctrl = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_bubble};

    pipe_hazard_ctrl #(.REG_W(5), .DMEM_TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .memread_ex(memread_ex), .writereg_ex(writereg_ex),
        .ins_rs(ins_rs), .ins_rt(ins_rt), .uses_rt_id(uses_rt_id), .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .idex_hold(idex_hold), .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .dmem_err(dmem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic br, input logic req, input logic rdy);
        memread_ex = mr; writereg_ex = wr; ins_rs = rs; ins_rt = rt;
        uses_rt_id = urt; branch_taken_ex = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{1, 5, 5, 0, 0, 0, 0, 0, LU};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, Z};
        tbl[2]  = '{1, 5, 3, 5, 0, 0, 0, 0, Z};
        tbl[3]  = '{1, 5, 3, 5, 1, 0, 0, 0, LU};
        tbl[4]  = '{0, 5, 5, 5, 1, 0, 0, 0, Z};
        tbl[5]  = '{1, 5, 5, 0, 0, 1, 0, 0, FLUSH};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, FLUSH};
        tbl[7]  = '{1, 5, 5, 0, 0, 1, 1, 0, HOLD};
        tbl[8]  = '{1, 5, 5, 0, 0, 0, 1, 1, LU};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, Z};
        tbl[10] = '{1, 31, 31, 0, 0, 0, 0, 0, LU};
        tbl[11] = '{1, 0, 1, 0, 1, 0, 0, 0, Z};

        repeat (2) @(negedge clk);
        #1 chk("reset_ctrl", ctrl, Z);
        chk("reset_cnt", stall_cnt, 0);
        @(negedge clk) rst_n = 1;
        #1 chk("post_reset_ctrl", ctrl, Z);
        chk("post_reset_err", dmem_err, 0);

        // combinational priority table, inputs back to idle before each edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].mr, tbl[i].wr, tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].br, tbl[i].req, tbl[i].rdy);
            #1 chk($sformatf("vec%0d", i), ctrl, tbl[i].exp);
            idle();
        end
        chk("table_cnt", stall_cnt, 0);

        // single load-use bubble
        @(negedge clk) drive(1, 5, 5, 0, 0, 0, 0, 0);
        #1 chk("lu_ctrl", ctrl, LU);
        @(negedge clk) drive(0, 0, 5, 0, 0, 0, 0, 0);
        #1 chk("lu_done_ctrl", ctrl, Z);
        chk("lu_cnt", stall_cnt, 1);

        // three-cycle memory wait, release with load-use pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) drive(0, 0, 0, 0, 0, 0, 1, 0);
            #1 chk($sformatf("mw_hold%0d", i), ctrl, HOLD);
        end
        @(negedge clk) drive(1, 7, 7, 0, 0, 1, 1, 1);
        #1 chk("mw_release_branch", ctrl, FLUSH);
        drive(1, 7, 7, 0, 0, 0, 1, 1);
        #1 chk("mw_release_lu", ctrl, LU);
        chk("mw_cnt", stall_cnt, 4);
        chk("mw_err", dmem_err, 0);
        @(negedge clk) drive(1, 8, 8, 0, 0, 0, 0, 0);
        #1 chk("lu2_first", ctrl, LU);
        chk("lu2_cnt_a", stall_cnt, 5);
        @(negedge clk) drive(1, 9, 0, 9, 1, 0, 0, 0);
        #1 chk("lu2_second", ctrl, LU);
        @(negedge clk) idle();
        #1 chk("lu2_done", ctrl, Z);
        chk("lu2_cnt_b", stall_cnt, 7);

        // timeout into ERR
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk) drive(0, 0, 0, 0, 0, 0, 1, 0);
            #1 chk($sformatf("to_err%0d", i), dmem_err, (i >= 17) ? 1 : 0);
            if (i == 16 || i == 20) chk($sformatf("to_hold%0d", i), ctrl, HOLD);
        end
        @(negedge clk) drive(1, 5, 5, 0, 0, 1, 1, 1);
        #1 chk("err_sticky", dmem_err, 1);
        chk("err_hold", ctrl, HOLD);
        chk("cnt_sat", stall_cnt, 15);
        @(negedge clk) idle();
        #1 chk("err_idle_hold", ctrl, HOLD);
        #1 rst_n = 0;
        #1 chk("err_rst_ctrl", ctrl, Z);
        chk("err_rst_err", dmem_err, 0);
        chk("err_rst_cnt", stall_cnt, 0);
        @(negedge clk) rst_n = 1;
        #1 chk("err_after_ctrl", ctrl, Z);

        // async reset in the middle of a memory wait
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        #1 chk("ar_before_cnt", stall_cnt, 1);
        @(negedge clk);
        #1 chk("ar_before_cnt2", stall_cnt, 2);
        #1 rst_n = 0;
        #1 chk("ar_ctrl", ctrl, Z);
        chk("ar_cnt", stall_cnt, 0);
        idle();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        #1 chk("ar_after_ctrl", ctrl, Z);
        chk("ar_after_cnt", stall_cnt, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("ar_run_state", ctrl, FLUSH);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
